// File: rtl/wb_sdram_arbiter_if.sv
// Wishbone B3 bus bundle shared by the SDRAM arbiter ports.
// master drives the request side, slave answers with data/ack/err.
interface wishbone_b3;
  logic [31:0] adr;
  logic [31:0] dat_m2s;
  logic [31:0] dat_s2m;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;

  modport master (
    output adr, dat_m2s, sel, cyc, stb, we, cti, bte,
    input  dat_s2m, ack, err
  );

  modport slave (
    input  adr, dat_m2s, sel, cyc, stb, we, cti, bte,
    output dat_s2m, ack, err
  );
endinterface

// File: rtl/wb_sdram_arbiter.sv
// Two-master Wishbone arbiter for the shared SDRAM port.
// m0 (screen DMA) has priority; m1 gets a starvation bound.
module wb_sdram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic       clk,
  input  logic       rst,
  wishbone_b3.slave  m0,
  wishbone_b3.slave  m1,
  wishbone_b3.master s,
  output logic [1:0] grant,
  output logic [7:0] timeouts
);
  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1,
    ABORT
  } state_t;

  localparam logic [7:0]  SLIM = 8'(STARVE_LIMIT);
  localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [7:0]  starve, starve_nx;
  logic [7:0]  to_nx;
  logic [15:0] wait_cnt, wait_nx;
  logic [1:0]  grant_nx;
  logic        ab1, ab1_nx;
  logic        own0, own1;
  logic        own_cyc, own_stb;
  logic        ab_cyc, forced, expire;

  assign own0    = (state == GNT0);
  assign own1    = (state == GNT1);
  assign own_cyc = (own0 & m0.cyc) | (own1 & m1.cyc);
  assign own_stb = (own0 & m0.stb) | (own1 & m1.stb);
  assign ab_cyc  = ab1 ? m1.cyc : m0.cyc;
  assign forced  = (starve == SLIM);

  // ack on the expiring cycle wins, so expiry needs a quiet slave
  assign expire = (own0 | own1) & own_stb
                & ~s.ack & ~s.err
                & (wait_cnt == TLIM);

  always_comb begin
    s.adr     = '0;
    s.dat_m2s = '0;
    s.sel     = '0;
    s.cti     = '0;
    s.bte     = '0;
    s.cyc     = 1'b0;
    s.stb     = 1'b0;
    s.we      = 1'b0;
    unique case (1'b1)
      own0: begin
        s.adr     = m0.adr;
        s.dat_m2s = m0.dat_m2s;
        s.sel     = m0.sel;
        s.cti     = m0.cti;
        s.bte     = m0.bte;
        s.cyc     = m0.cyc;
        s.stb     = m0.stb;
        s.we      = m0.we;
      end
      own1: begin
        s.adr     = m1.adr;
        s.dat_m2s = m1.dat_m2s;
        s.sel     = m1.sel;
        s.cti     = m1.cti;
        s.bte     = m1.bte;
        s.cyc     = m1.cyc;
        s.stb     = m1.stb;
        s.we      = m1.we;
      end
      default: ;
    endcase
  end

  assign m0.ack     = own0 & s.ack & ~expire;
  assign m0.err     = own0 & (s.err | expire);
  assign m1.ack     = own1 & s.ack & ~expire;
  assign m1.err     = own1 & (s.err | expire);
  assign m0.dat_s2m = s.dat_s2m;
  assign m1.dat_s2m = s.dat_s2m;

  always_comb begin
    state_nx  = state;
    starve_nx = starve;
    wait_nx   = wait_cnt;
    to_nx     = timeouts;
    ab1_nx    = ab1;
    unique case (state)
      IDLE: begin
        wait_nx = '0;
        if (forced && m1.cyc) begin
          state_nx  = GNT1;
          starve_nx = '0;
        end else if (m0.cyc) begin
          state_nx = GNT0;
        end else if (m1.cyc) begin
          state_nx  = GNT1;
          starve_nx = '0;
        end
      end
      GNT0, GNT1: begin
        if (expire) begin
          state_nx = ABORT;
          wait_nx  = '0;
          ab1_nx   = own1;
          if (timeouts != 8'hff)
            to_nx = timeouts + 8'd1;
        end else if (!own_cyc) begin
          state_nx = IDLE;
          wait_nx  = '0;
          if (own0 && m1.cyc && !forced)
            starve_nx = starve + 8'd1;
        end else if (s.ack || s.err) begin
          wait_nx = '0;
        end else if (own_stb) begin
          wait_nx = wait_cnt + 16'd1;
        end
      end
      ABORT: begin
        wait_nx = '0;
        if (!ab_cyc)
          state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    grant_nx = 2'b00;
    if (state_nx == GNT0)
      grant_nx = 2'b01;
    else if (state_nx == GNT1)
      grant_nx = 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= 2'b00;
      timeouts <= 8'd0;
      starve   <= 8'd0;
      wait_cnt <= 16'd0;
      ab1      <= 1'b0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      timeouts <= to_nx;
      starve   <= starve_nx;
      wait_cnt <= wait_nx;
      ab1      <= ab1_nx;
    end
  end
endmodule

// File: doc/wb_sdram_arbiter.md
# wb_sdram_arbiter

Two-master, one-slave Wishbone B3 arbiter that shares the single SDRAM port between the screen DMA (m0, high priority) and the ThermoProcessor data bus (m1). It sits on the proc_clk side, ahead of the fast-clock bridge into the SDRAM controller. It grants whole bus cycles (cyc tenures), never interleaves beats, bounds processor starvation and aborts hung slave accesses with a bus error.

## Interface
- STARVE_LIMIT, 4: consecutive m0 tenures allowed while m1 waits before m1 is forced in (1..255)
- TIMEOUT, 1024: cycles of stb without ack/err before abort (2..65535)
- clk  in  1  processor clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- m0  wishbone_b3 slave modport  intf  screen DMA master port
- m1  wishbone_b3 slave modport  intf  processor master port
- s  wishbone_b3 master modport  intf  to SDRAM bridge
- grant  out  2  one-hot current owner ({m1,m0}); 2'b00 when idle/abort
- timeouts  out  8  saturating count of aborted accesses
- Fields used per interface: adr[31:0], dat_m2s[31:0], dat_s2m[31:0], sel[3:0], cyc, stb, we, cti[2:0], bte[1:0], ack, err.

## Operation
- States: IDLE, GNT0, GNT1, ABORT. Reset: IDLE, grant=0, timeouts=0, starve counter=0, wait counter=0.
- IDLE: if forced (starve counter == STARVE_LIMIT) and m1.cyc -> GNT1; else m0.cyc -> GNT0; else m1.cyc -> GNT1; else stay.
- GNTx: s.adr/dat_m2s/sel/we/cti/bte/cyc/stb driven from master x; s.ack/err routed only to master x. Non-owner: ack=0, err=0. dat_s2m broadcast to both.
- GNTx -> IDLE on the edge where master x samples cyc=0. Beats of a burst (cti=010) never lose grant.
- Starve counter: on GNT0 -> IDLE, increments (saturating at STARVE_LIMIT) if m1.cyc=1 that cycle; cleared on IDLE -> GNT1.
- Wait counter: in GNTx, increments each cycle with s.stb=1 and s.ack=0 and s.err=0; cleared by ack, err, or state change.
- Abort: when wait counter reaches TIMEOUT-1 with no ack/err, that cycle master x gets err=1 (s.ack ignored) and state -> ABORT; timeouts increments (saturates at 255).
- ABORT: s.cyc=s.stb=0, both masters see ack=err=0; -> IDLE when the aborted master drops cyc.
- IDLE/ABORT: s.cyc=s.stb=s.we=0; other s outputs don't-care (driven 0).

## Timing
- Arbitration latency: master asserts cyc in cycle N (IDLE) -> grant registered at edge N+1 -> s.cyc/stb visible in cycle N+1, combinational pass-through thereafter.
- ack/err path slave -> owner is combinational (zero added latency); no registered data.
- Release-to-next-grant: one IDLE cycle minimum between tenures.
- Simultaneous cyc in IDLE: m0 wins unless forced.
- ack and timeout in same cycle: ack wins, no abort.
- rst mid-tenure: immediately IDLE, s.cyc=0, all counters and timeouts cleared.
- grant outputs registered (equal state encoding).

## Test plan
- Single m1 write, adr=0x100, dat=0xDEADBEEF, slave acks 3 cycles after stb -> s sees transaction one cycle after m1.cyc; m1.ack one pulse; grant=2'b10 then 2'b00.
- m0 and m1 assert cyc same cycle -> grant=2'b01 first; m1 granted one IDLE cycle after m0 drops cyc; m1 never sees ack during m0 tenure.
- m0 8-beat burst (cti=010, last 111), m1 requesting throughout -> grant stays 2'b01 for all 8 acks, no interleave.
- STARVE_LIMIT=4, m0 requests continuously in back-to-back single tenures, m1 holds cyc -> after 4th m0 tenure, m1 granted even though m0.cyc=1; counter resets.
- TIMEOUT=16, slave never acks m1 read -> m1.err pulses exactly 16th stb cycle, s.cyc drops next cycle, timeouts=1; ABORT held until m1 drops cyc; repeat 300 times -> timeouts saturates at 255.
- Assert rst during GNT0 mid-burst -> s.cyc=0 and grant=0 same cycle (async), timeouts=0; after release normal arbitration resumes.
